// File: rtl/axi_10g_ethernet_0_tx_arbiter.sv
// Packet-level arbiter sharing the 10G MAC TX AXI4-Stream between the ARP
// reply, ARP request and TCP/IP sources. Fixed priority with a TCP starvation
// guard, zero-latency data mux, and a per-frame beat watchdog that truncates
// over-long frames and drains the rest of the offending source frame.
module axi_10g_ethernet_0_tx_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned MAX_BEATS    = 190
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [63:0] s_reply_tdata,
   input  logic [7:0]  s_reply_tkeep,
   input  logic        s_reply_tvalid,
   input  logic        s_reply_tlast,
   output logic        s_reply_tready,
   input  logic [63:0] s_request_tdata,
   input  logic [7:0]  s_request_tkeep,
   input  logic        s_request_tvalid,
   input  logic        s_request_tlast,
   output logic        s_request_tready,
   input  logic [63:0] s_tcp_tdata,
   input  logic [7:0]  s_tcp_tkeep,
   input  logic        s_tcp_tvalid,
   input  logic        s_tcp_tlast,
   output logic        s_tcp_tready,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic        reply_done,
   output logic        request_done,
   output logic        tcp_done,
   output logic [2:0]  grant,
   output logic        trunc_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REPLY,
      ST_REQUEST,
      ST_TCP,
      ST_DRAIN
   } state_t;

   localparam logic [3:0]  STREAK_MAX = 4'(STARVE_LIMIT);
   localparam logic [15:0] LAST_BEAT  = 16'(MAX_BEATS - 1);

   // One-hot source codes, bit order {tcp, request, reply} to match grant
   localparam logic [2:0] SRC_REPLY   = 3'b001;
   localparam logic [2:0] SRC_REQUEST = 3'b010;
   localparam logic [2:0] SRC_TCP     = 3'b100;

   state_t      state_q, state_d;
   logic [2:0]  drain_src_q, drain_src_d;
   logic [3:0]  streak_q, streak_d;
   logic [15:0] beat_cnt_q, beat_cnt_d;
   logic [2:0]  grant_q, grant_d;
   logic [2:0]  done_q, done_d;
   logic        trunc_q, trunc_d;

   logic [2:0]  sel;
   logic [63:0] sel_tdata;
   logic [7:0]  sel_tkeep;
   logic        sel_tvalid;
   logic        sel_tlast;
   logic        at_limit;
   logic        owner_hs;
   logic [3:0]  arp_streak;

   assign at_limit = (beat_cnt_q == LAST_BEAT);

   // Streak value after an ARP win: counts only while TCP is being held off
   assign arp_streak = !s_tcp_tvalid ? 4'd0 :
                       (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;

   // Select the stream of the source that owns the port or is being drained
   always_comb begin
      sel = 3'b000;
      case (state_q)
         ST_REPLY:   sel = SRC_REPLY;
         ST_REQUEST: sel = SRC_REQUEST;
         ST_TCP:     sel = SRC_TCP;
         ST_DRAIN:   sel = drain_src_q;
         default:    sel = 3'b000;
      endcase
      sel_tdata  = ({64{sel[0]}} & s_reply_tdata) | ({64{sel[1]}} & s_request_tdata) |
                   ({64{sel[2]}} & s_tcp_tdata);
      sel_tkeep  = ({8{sel[0]}} & s_reply_tkeep) | ({8{sel[1]}} & s_request_tkeep) |
                   ({8{sel[2]}} & s_tcp_tkeep);
      sel_tvalid = |(sel & {s_tcp_tvalid, s_request_tvalid, s_reply_tvalid});
      sel_tlast  = |(sel & {s_tcp_tlast, s_request_tlast, s_reply_tlast});
   end

   // MAC-side outputs and source backpressure; tlast forced on the watchdog beat
   always_comb begin
      m_axis_tdata     = '0;
      m_axis_tkeep     = '0;
      m_axis_tvalid    = 1'b0;
      m_axis_tlast     = 1'b0;
      s_reply_tready   = 1'b0;
      s_request_tready = 1'b0;
      s_tcp_tready     = 1'b0;
      owner_hs         = 1'b0;
      case (state_q)
         ST_REPLY, ST_REQUEST, ST_TCP: begin
            m_axis_tdata  = sel_tdata;
            m_axis_tkeep  = sel_tkeep;
            m_axis_tvalid = sel_tvalid;
            m_axis_tlast  = sel_tlast | at_limit;
            {s_tcp_tready, s_request_tready, s_reply_tready} = sel & {3{m_axis_tready}};
            owner_hs      = sel_tvalid & m_axis_tready;
         end
         ST_DRAIN: begin
            {s_tcp_tready, s_request_tready, s_reply_tready} = sel;
         end
         default: ;
      endcase
   end

   // Arbitration, frame tracking, watchdog truncation and drain sequencing
   always_comb begin
      state_d     = state_q;
      drain_src_d = drain_src_q;
      streak_d    = streak_q;
      beat_cnt_d  = beat_cnt_q;
      done_d      = 3'b000;
      trunc_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            beat_cnt_d = '0;
            if (s_tcp_tvalid && (streak_q == STREAK_MAX)) begin
               state_d  = ST_TCP;
               streak_d = '0;
            end else if (s_reply_tvalid) begin
               state_d  = ST_REPLY;
               streak_d = arp_streak;
            end else if (s_request_tvalid) begin
               state_d  = ST_REQUEST;
               streak_d = arp_streak;
            end else if (s_tcp_tvalid) begin
               state_d  = ST_TCP;
               streak_d = '0;
            end
         end
         ST_REPLY, ST_REQUEST, ST_TCP: begin
            if (owner_hs) begin
               beat_cnt_d = beat_cnt_q + 16'd1;
               if (sel_tlast) begin
                  done_d  = sel;
                  state_d = ST_IDLE;
               end else if (at_limit) begin
                  trunc_d     = 1'b1;
                  drain_src_d = sel;
                  state_d     = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (sel_tvalid && sel_tlast) begin
               done_d  = sel;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_REPLY:   grant_d = SRC_REPLY;
         ST_REQUEST: grant_d = SRC_REQUEST;
         ST_TCP:     grant_d = SRC_TCP;
         default:    grant_d = 3'b000;
      endcase
   end

   // State and registered grant/pulse outputs with synchronous active-low reset
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= ST_IDLE;
         drain_src_q <= 3'b000;
         streak_q    <= '0;
         beat_cnt_q  <= '0;
         grant_q     <= 3'b000;
         done_q      <= 3'b000;
         trunc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_src_q <= drain_src_d;
         streak_q    <= streak_d;
         beat_cnt_q  <= beat_cnt_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         trunc_q     <= trunc_d;
      end
   end

   assign grant = grant_q;
   assign {tcp_done, request_done, reply_done} = done_q;
   assign trunc_err = trunc_q;

endmodule

// File: tb/tb_axi_10g_ethernet_0_tx_arbiter.sv
// Bench for the 10G TX arbiter: queue-fed sources, a cycle-level behavioural
// model compared every cycle, and literal expectations per scenario.
module tb_axi_10g_ethernet_0_tx_arbiter;
   localparam int STARVE_LIMIT = 4;
   localparam int MAX_BEATS    = 4;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] s_reply_tdata, s_request_tdata, s_tcp_tdata, m_axis_tdata;
   logic [7:0]  s_reply_tkeep, s_request_tkeep, s_tcp_tkeep, m_axis_tkeep;
   logic        s_reply_tvalid, s_request_tvalid, s_tcp_tvalid, m_axis_tvalid;
   logic        s_reply_tlast, s_request_tlast, s_tcp_tlast, m_axis_tlast;
   logic        s_reply_tready, s_request_tready, s_tcp_tready, m_axis_tready;
   logic        reply_done, request_done, tcp_done, trunc_err;
   logic [2:0]  grant;

   always #5 aclk = ~aclk;

   axi_10g_ethernet_0_tx_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_BEATS(MAX_BEATS)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_reply_tdata(s_reply_tdata), .s_reply_tkeep(s_reply_tkeep),
      .s_reply_tvalid(s_reply_tvalid), .s_reply_tlast(s_reply_tlast),
      .s_reply_tready(s_reply_tready),
      .s_request_tdata(s_request_tdata), .s_request_tkeep(s_request_tkeep),
      .s_request_tvalid(s_request_tvalid), .s_request_tlast(s_request_tlast),
      .s_request_tready(s_request_tready),
      .s_tcp_tdata(s_tcp_tdata), .s_tcp_tkeep(s_tcp_tkeep),
      .s_tcp_tvalid(s_tcp_tvalid), .s_tcp_tlast(s_tcp_tlast),
      .s_tcp_tready(s_tcp_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready),
      .reply_done(reply_done), .request_done(request_done), .tcp_done(tcp_done),
      .grant(grant), .trunc_err(trunc_err)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [2:0]  grant;
      logic        mvalid;
      logic        mlast;
      logic [63:0] mdata;
      logic [2:0]  tready;
      logic [2:0]  done;
      logic        trunc;
   } obs_t;

   beat_t q_rep[$];
   beat_t q_req[$];
   beat_t q_tcp[$];
   obs_t  trace[$];
   int    frm_src[$];
   int    frm_beats[$];
   int    out_beats = 0;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model: who owns the port, whether draining, beats sent so far,
   // consecutive ARP wins while TCP waits, and pulses due this cycle.
   int         m_owner  = -1;
   bit         m_drain  = 1'b0;
   int         m_beats  = 0;
   int         m_streak = 0;
   logic [2:0] m_done   = 3'b000;
   bit         m_trunc  = 1'b0;
   bit         m_known  = 1'b0;
   logic       mtready  = 1'b1;

   bit pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic src_valid(input int i);
      case (i)
         0:       return s_reply_tvalid;
         1:       return s_request_tvalid;
         2:       return s_tcp_tvalid;
         default: return 1'b0;
      endcase
   endfunction

   function automatic beat_t src_beat(input int i);
      beat_t b;
      b = '0;
      case (i)
         0: b = '{s_reply_tdata, s_reply_tkeep, s_reply_tlast};
         1: b = '{s_request_tdata, s_request_tkeep, s_request_tlast};
         2: b = '{s_tcp_tdata, s_tcp_tkeep, s_tcp_tlast};
         default: b = '0;
      endcase
      return b;
   endfunction

   function automatic int onehot2idx(input logic [2:0] g);
      case (g)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return -1;
      endcase
   endfunction

   task automatic push_frame(input int src, input int n, input int tag);
      beat_t b;
      for (int i = 1; i <= n; i++) begin
         b.data = {8'hA0 + 8'(src), 8'(tag), 32'h0, 16'(i)};
         b.keep = (i == n) ? 8'h0F : 8'hFF;
         b.last = (i == n);
         case (src)
            0:       q_rep.push_back(b);
            1:       q_req.push_back(b);
            default: q_tcp.push_back(b);
         endcase
      end
   endtask

   task automatic drive_inputs();
      beat_t z;
      z = '0;
      m_axis_tready = mtready;
      s_reply_tvalid   = (q_rep.size() != 0);
      s_request_tvalid = (q_req.size() != 0);
      s_tcp_tvalid     = (q_tcp.size() != 0);
      {s_reply_tdata, s_reply_tkeep, s_reply_tlast}       = (q_rep.size() != 0) ? q_rep[0] : z;
      {s_request_tdata, s_request_tkeep, s_request_tlast} = (q_req.size() != 0) ? q_req[0] : z;
      {s_tcp_tdata, s_tcp_tkeep, s_tcp_tlast}             = (q_tcp.size() != 0) ? q_tcp[0] : z;
   endtask

   // Expected outputs for the current cycle from the model state and live inputs
   task automatic compare();
      beat_t      b;
      bit         act;
      logic [2:0] e_grant, e_tready;
      if (!m_known) return;
      act      = (m_owner >= 0) && !m_drain;
      b        = src_beat(m_owner);
      e_grant  = act ? 3'(1 << m_owner) : 3'b000;
      e_tready = (m_owner >= 0) ? (3'(1 << m_owner) & (m_drain ? 3'b111 : {3{mtready}})) : 3'b000;
      chk("grant", grant, e_grant);
      chk("s_tready", {s_tcp_tready, s_request_tready, s_reply_tready}, e_tready);
      chk("m_tvalid", m_axis_tvalid, act & src_valid(m_owner));
      chk("m_tdata", m_axis_tdata, act ? b.data : 64'h0);
      chk("m_tkeep", m_axis_tkeep, act ? b.keep : 8'h0);
      chk("m_tlast", m_axis_tlast, act ? (b.last | (m_beats == MAX_BEATS - 1)) : 1'b0);
      chk("done", {tcp_done, request_done, reply_done}, m_done);
      chk("trunc_err", trunc_err, m_trunc);
   endtask

   task automatic model_update();
      bit    v;
      beat_t b;
      if (!aresetn) begin
         m_known = 1'b1; m_owner = -1; m_drain = 1'b0; m_beats = 0;
         m_streak = 0; m_done = 3'b000; m_trunc = 1'b0;
         return;
      end
      if (!m_known) return;
      m_done  = 3'b000;
      m_trunc = 1'b0;
      if (m_owner < 0) begin
         m_beats = 0;
         if (s_tcp_tvalid && m_streak == STARVE_LIMIT) begin
            m_owner = 2; m_streak = 0;
         end else if (s_reply_tvalid || s_request_tvalid) begin
            m_owner  = s_reply_tvalid ? 0 : 1;
            m_streak = s_tcp_tvalid ? ((m_streak < STARVE_LIMIT) ? m_streak + 1 : m_streak) : 0;
         end else if (s_tcp_tvalid) begin
            m_owner = 2; m_streak = 0;
         end
      end else begin
         v = src_valid(m_owner);
         b = src_beat(m_owner);
         if (!m_drain) begin
            if (v && mtready) begin
               if (b.last) begin
                  m_done  = 3'(1 << m_owner);
                  m_owner = -1;
               end else if (m_beats == MAX_BEATS - 1) begin
                  m_trunc = 1'b1;
                  m_drain = 1'b1;
               end
               m_beats++;
            end
         end else if (v && b.last) begin
            m_done  = 3'(1 << m_owner);
            m_owner = -1;
            m_drain = 1'b0;
         end
      end
   endtask

   // One clock: drive at the falling edge, check 1ns later, advance at the rising edge
   task automatic tick();
      obs_t       o;
      logic [2:0] hs;
      drive_inputs();
      #1;
      compare();
      o.grant  = grant;
      o.mvalid = m_axis_tvalid;
      o.mlast  = m_axis_tlast;
      o.mdata  = m_axis_tdata;
      o.tready = {s_tcp_tready, s_request_tready, s_reply_tready};
      o.done   = {tcp_done, request_done, reply_done};
      o.trunc  = trunc_err;
      trace.push_back(o);
      hs = {s_tcp_tvalid & s_tcp_tready, s_request_tvalid & s_request_tready,
            s_reply_tvalid & s_reply_tready};
      if (m_axis_tvalid && m_axis_tready) begin
         out_beats++;
         if (m_axis_tlast) begin
            frm_src.push_back(onehot2idx(grant));
            frm_beats.push_back(out_beats);
            out_beats = 0;
         end
      end
      @(posedge aclk);
      model_update();
      if (!aresetn) begin
         q_rep.delete(); q_req.delete(); q_tcp.delete();
         out_beats = 0;
      end else begin
         if (hs[0]) void'(q_rep.pop_front());
         if (hs[1]) void'(q_req.pop_front());
         if (hs[2]) void'(q_tcp.pop_front());
      end
      @(negedge aclk);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
      tick();
      trace.delete();
      frm_src.delete();
      frm_beats.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      logic [2:0] exp_g[11];
      int exp_order[8];
      aresetn = 1'b0;
      mtready = 1'b1;
      @(negedge aclk);

      // Reset state: everything quiet while and after reset is applied
      aresetn = 1'b0;
      tick();
      tick();
      chk("rst_grant", trace[1].grant, 3'b000);
      chk("rst_mvalid", trace[1].mvalid, 1'b0);
      chk("rst_tready", trace[1].tready, 3'b000);
      chk("rst_done", {trace[1].done, trace[1].trunc}, 4'b0000);
      aresetn = 1'b1;
      tick();
      trace.delete();

      // Single source: 3-beat TCP frame
      do_reset();
      mtready = 1'b1;
      push_frame(2, 3, 1);
      repeat (6) tick();
      chk("t1_grant_c0", trace[0].grant, 3'b000);
      for (int k = 1; k <= 3; k++) begin
         chk("t1_grant_beat", trace[k].grant, 3'b100);
         chk("t1_valid_beat", trace[k].mvalid, 1'b1);
      end
      chk("t1_last_c2", trace[2].mlast, 1'b0);
      chk("t1_last_c3", trace[3].mlast, 1'b1);
      chk("t1_done_c3", trace[3].done, 3'b000);
      chk("t1_done_c4", trace[4].done, 3'b100);
      chk("t1_grant_c4", trace[4].grant, 3'b000);
      chk("t1_done_c5", trace[5].done, 3'b000);

      // Priority: all three sources valid together, 2-beat frames
      do_reset();
      push_frame(0, 2, 2);
      push_frame(1, 2, 2);
      push_frame(2, 2, 2);
      repeat (11) tick();
      exp_g = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
      for (int k = 0; k < 11; k++) chk("t2_grant_seq", trace[k].grant, exp_g[k]);
      chk("t2_nframes", frm_src.size(), 3);
      if (frm_src.size() == 3) begin
         chk("t2_order0", frm_src[0], 0);
         chk("t2_order1", frm_src[1], 1);
         chk("t2_order2", frm_src[2], 2);
      end

      // Starvation guard: TCP held valid behind continuous ARP traffic
      do_reset();
      for (int k = 0; k < 3; k++) push_frame(0, 1, 10 + k);
      for (int k = 0; k < 3; k++) push_frame(1, 1, 20 + k);
      for (int k = 0; k < 2; k++) push_frame(2, 1, 30 + k);
      cnt = 0;
      while ((q_rep.size() + q_req.size() + q_tcp.size() != 0 || m_owner >= 0) && cnt < 60) begin
         tick();
         cnt++;
      end
      chk("t3_within_budget", (cnt < 60), 1'b1);
      tick();
      exp_order = '{0, 0, 0, 1, 2, 1, 1, 2};
      chk("t3_nframes", frm_src.size(), 8);
      if (frm_src.size() == 8)
         for (int k = 0; k < 8; k++) chk("t3_order", frm_src[k], exp_order[k]);

      // Backpressure: ready 1,0,0,1 across the frame
      do_reset();
      push_frame(2, 4, 4);
      for (int k = 0; k < 8; k++) begin
         mtready = pat[k];
         tick();
      end
      mtready = 1'b1;
      chk("t4_data_c2", trace[2].mdata, 64'hA204_0000_0000_0002);
      chk("t4_data_c3", trace[3].mdata, 64'hA204_0000_0000_0002);
      chk("t4_data_c4", trace[4].mdata, 64'hA204_0000_0000_0002);
      chk("t4_data_c5", trace[5].mdata, 64'hA204_0000_0000_0003);
      chk("t4_tready_c1", trace[1].tready, 3'b100);
      chk("t4_tready_c2", trace[2].tready, 3'b000);
      chk("t4_tready_c3", trace[3].tready, 3'b000);
      chk("t4_tready_c4", trace[4].tready, 3'b100);
      chk("t4_last_c6", trace[6].mlast, 1'b1);
      chk("t4_done_c6", trace[6].done, 3'b000);
      chk("t4_done_c7", trace[7].done, 3'b100);

      // Watchdog: 7-beat request frame truncated at 4 beats, remainder drained
      do_reset();
      push_frame(1, 7, 5);
      repeat (10) tick();
      for (int k = 1; k <= 4; k++) chk("t5_valid_beat", trace[k].mvalid, 1'b1);
      chk("t5_last_c3", trace[3].mlast, 1'b0);
      chk("t5_last_c4", trace[4].mlast, 1'b1);
      chk("t5_data_c4", trace[4].mdata, 64'hA105_0000_0000_0004);
      chk("t5_trunc_c4", trace[4].trunc, 1'b0);
      chk("t5_trunc_c5", trace[5].trunc, 1'b1);
      chk("t5_trunc_c6", trace[6].trunc, 1'b0);
      for (int k = 5; k <= 7; k++) begin
         chk("t5_drain_valid", trace[k].mvalid, 1'b0);
         chk("t5_drain_tready", trace[k].tready, 3'b010);
         chk("t5_drain_grant", trace[k].grant, 3'b000);
      end
      chk("t5_done_c7", trace[7].done, 3'b000);
      chk("t5_done_c8", trace[8].done, 3'b010);
      chk("t5_src_empty", q_req.size(), 0);
      chk("t5_nframes", frm_src.size(), 1);
      if (frm_src.size() == 1) begin
         chk("t5_frame_src", frm_src[0], 1);
         chk("t5_frame_beats", frm_beats[0], 4);
      end

      // Reset during beat 2 of a reply frame, then a fresh TCP frame
      do_reset();
      push_frame(0, 4, 6);
      tick();
      tick();
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      tick();
      chk("t6_data_c2", trace[2].mdata, 64'hA006_0000_0000_0002);
      chk("t6_grant_c3", trace[3].grant, 3'b000);
      chk("t6_mvalid_c3", trace[3].mvalid, 1'b0);
      chk("t6_mdata_c3", trace[3].mdata, 64'h0);
      chk("t6_tready_c3", trace[3].tready, 3'b000);
      chk("t6_pulses_c3", {trace[3].done, trace[3].trunc}, 4'b0000);
      push_frame(2, 1, 7);
      repeat (3) tick();
      chk("t6_grant_c4", trace[4].grant, 3'b000);
      chk("t6_grant_c5", trace[5].grant, 3'b100);
      chk("t6_beat_c5", {trace[5].mvalid, trace[5].mlast}, 2'b11);
      chk("t6_data_c5", trace[5].mdata, 64'hA207_0000_0000_0001);
      chk("t6_done_c6", trace[6].done, 3'b100);
      chk("t6_nframes", frm_src.size(), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axi_10g_ethernet_0_tx_arbiter.md
# axi_10g_ethernet_0_tx_arbiter

Packet-level arbiter that shares the single 64-bit AXI4-Stream TX port of the 10G MAC between three frame sources: ARP reply, ARP request and TCP/IP data. It sits between the ARP block and TCP transmit path on one side and the MAC TX interface on the other. Each frame is locked to one source from first beat to `tlast`. Arbitration is fixed priority with a starvation guard for TCP, and a per-frame beat watchdog.

## Interface
- `STARVE_LIMIT`, 4, consecutive ARP grants allowed while TCP is waiting; range 1..15.
- `MAX_BEATS`, 190, maximum beats per frame before forced truncation; range 2..65535.
- `aclk` in 1 — single clock; all logic on its rising edge.
- `aresetn` in 1 — reset, synchronous, active-low.
- `s_reply_tdata/tkeep/tvalid/tlast` in 64/8/1/1 — ARP reply frame stream.
- `s_reply_tready` out 1 — backpressure to ARP reply source.
- `s_request_tdata/tkeep/tvalid/tlast` in 64/8/1/1 — ARP request frame stream.
- `s_request_tready` out 1
- `s_tcp_tdata/tkeep/tvalid/tlast` in 64/8/1/1 — TCP/IP frame stream.
- `s_tcp_tready` out 1
- `m_axis_tdata/tkeep/tvalid/tlast` out 64/8/1/1 — to MAC TX.
- `m_axis_tready` in 1 — from MAC TX.
- `reply_done`, `request_done`, `tcp_done` out 1 each — one-cycle pulse after that source's frame completes.
- `grant` out 3 — one-hot current owner {tcp, request, reply}; 0 when idle or draining.
- `trunc_err` out 1 — one-cycle pulse when the watchdog truncates a frame.

## Operation
- States: IDLE, REPLY, REQUEST, TCP, DRAIN.
- IDLE: all `s_*_tready`=0, `m_axis_tvalid`=0. If any `s_*_tvalid`=1, the arbiter picks a winner and registers it. The next state is the winner's state.
- Winner order: reply > request > tcp.
- Starvation override: if `s_tcp_tvalid`=1 and `streak`==`STARVE_LIMIT`, TCP wins regardless of ARP requests.
- `streak` (4-bit):
  - Increments when an ARP source wins while `s_tcp_tvalid`=1.
  - Clears when TCP wins, or when an arbitration occurs with `s_tcp_tvalid`=0.
  - Saturates at `STARVE_LIMIT`.
- Owner state (REPLY/REQUEST/TCP):
  - `m_axis_tdata/tkeep/tvalid/tlast` = owner's signals, combinational mux.
  - Owner `tready` = `m_axis_tready`; non-owners' `tready`=0.
- Beat counter (16-bit):
  - Cleared in IDLE; increments on each `m_axis_tvalid & m_axis_tready`.
  - On a handshake with owner `tlast`=1: pulse the owner's `*_done` on the next cycle; state goes to IDLE.
- Watchdog: if the handshake beat is beat number `MAX_BEATS` (counter==`MAX_BEATS`-1) and owner `tlast`=0:
  - `m_axis_tlast` is forced to 1 on that beat.
  - `trunc_err` pulses next cycle; state goes to DRAIN.
- DRAIN:
  - `m_axis_tvalid`=0; the truncated source's `tready`=1; its beats are discarded.
  - On a source beat with `tlast`=1: pulse that source's `*_done`, go to IDLE.
- Source `tvalid` dropping mid-frame: owner keeps the grant; output `tvalid` follows. No timeout.

## Timing
- Reset (`aresetn`=0 at a clock edge): state IDLE, `streak`=0, beat counter=0. All outputs 0: `m_axis_*`, all `s_*_tready`, `grant`, `*_done`, `trunc_err`.
- Reset mid-frame: the MAC frame is abandoned without `tlast`; sources must also be reset.
- Latency: source `tvalid` sampled in IDLE at cycle N → first output beat valid at N+1. No output register, zero data latency.
- Frames are separated by at least one IDLE cycle: the `tlast` handshake at cycle M is followed by IDLE at M+1 and the next grant at M+2.
- `*_done` and `trunc_err` are asserted exactly one cycle after the triggering handshake.
- Simultaneous `tvalid` from all three sources in IDLE: reply wins unless the starvation override applies.
- `grant` is a registered output and matches the state.
- A single-beat frame (`tlast` on the first beat) is legal: counter==0, no truncation.

## Test plan
- **Single source:** a 3-beat TCP frame with `m_axis_tready`=1 → output beats at cycles 1–3 with `grant`=3'b100; `tcp_done` pulses at cycle 4; `grant`=0 at cycle 4.
- **Priority:** reply, request and TCP all valid in the same cycle with 2-beat frames → output order reply, request, tcp; each frame separated by exactly one idle cycle.
- **Starvation:** `STARVE_LIMIT`=4, TCP held valid, ARP sources continuously valid → exactly 4 ARP frames, then one TCP frame, then ARP resumes; `streak` returns to 0.
- **Backpressure:** `m_axis_tready` toggled 1,0,0,1 during a 4-beat frame → data unchanged while stalled; owner `tready` mirrors `m_axis_tready`; `tcp_done` pulses only after the final beat's handshake.
- **Watchdog:** `MAX_BEATS`=4, a 7-beat request frame → 4 output beats with `tlast` on beat 4; `trunc_err` pulses; beats 5–7 are consumed with `m_axis_tvalid`=0; `request_done` pulses after beat 7.
- **Reset mid-frame:** `aresetn`=0 during beat 2 of a reply frame → next cycle all outputs 0 and state IDLE; after release, a fresh TCP frame is granted normally.
